// File: rtl/debounce_scan_scheduler.sv
// Round-robin majority-vote debouncer: one counting engine shared
// across N_BTN buttons, one time slot per button.
module debounce_scan_scheduler #(
  parameter int N_BTN      = 4,
  parameter int WINDOW     = 50000,
  parameter int THRESHOLD  = 40000,
  parameter int RELEASE_TH = 10000,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_BTN-1:0]         button_in,
  output logic [N_BTN-1:0]         button_out,
  output logic [N_BTN-1:0]         press_pulse,
  output logic [N_BTN-1:0]         release_pulse,
  output logic [$clog2(N_BTN)-1:0] scan_idx,
  output logic                     busy
);

  localparam int IW = $clog2(N_BTN);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;

  localparam logic [CNT_W-1:0] L_TH  = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] L_REL = CNT_W'(RELEASE_TH);
  localparam logic [CNT_W-1:0] L_WIN = CNT_W'(WINDOW);
  localparam logic [IW-1:0]    L_LAST = IW'(N_BTN - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] r_total;
  logic [IW-1:0]    r_idx;
  logic [N_BTN-1:0] r_btn;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_rel;

  logic             w_b;
  logic [CNT_W-1:0] w_ones_n;
  logic [CNT_W-1:0] w_total_n;
  logic             w_done;
  logic             w_cur;
  logic             w_lvl;
  logic [IW-1:0]    w_idx_n;

  // Sample path, window-end detection and the hysteresis verdict
  always_comb begin
    w_b       = button_in[r_idx];
    w_ones_n  = r_ones + {{(CNT_W-1){1'b0}}, w_b};
    w_total_n = r_total + {{(CNT_W-1){1'b0}}, 1'b1};
    w_done    = (w_ones_n == L_TH) || (w_total_n == L_WIN);
    w_cur     = r_btn[r_idx];
    if (r_ones >= L_TH)       w_lvl = 1'b1;
    else if (r_ones <= L_REL) w_lvl = 1'b0;
    else                      w_lvl = w_cur;
    w_idx_n = (r_idx == L_LAST) ? '0 : r_idx + IW'(1);
  end

  // Slot FSM: counters, debounced levels, pulses and scan pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ones  <= '0;
      r_total <= '0;
      r_idx   <= '0;
      r_btn   <= '0;
      r_press <= '0;
      r_rel   <= '0;
    end else begin
      r_press <= '0;
      r_rel   <= '0;
      case (r_state)
        S_IDLE: begin
          r_ones  <= '0;
          r_total <= '0;
          if (enable) r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (!enable) begin
            r_ones  <= '0;
            r_total <= '0;
            r_state <= S_IDLE;
          end else begin
            r_ones  <= w_ones_n;
            r_total <= w_total_n;
            if (w_done) r_state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          r_btn[r_idx]   <= w_lvl;
          r_press[r_idx] <= w_lvl & ~w_cur;
          r_rel[r_idx]   <= ~w_lvl & w_cur;
          r_ones         <= '0;
          r_total        <= '0;
          r_idx          <= w_idx_n;
          r_state        <= enable ? S_SAMPLE : S_IDLE;
        end
        default: begin
          r_ones  <= '0;
          r_total <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign button_out    = r_btn;
  assign press_pulse   = r_press;
  assign release_pulse = r_rel;
  assign scan_idx      = r_idx;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// Scoreboard bench for debounce_scan_scheduler: expected pulse events
// are queued by the stimulus and popped by an independent monitor.
module tb_debounce_scan_scheduler;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int TH = 8;
  localparam int RL = 2;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [N-1:0] button_in;
  logic [N-1:0] button_out;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [1:0]   scan_idx;
  logic         busy;

  typedef struct packed {
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] out;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  debounce_scan_scheduler #(
    .N_BTN(N), .WINDOW(W), .THRESHOLD(TH),
    .RELEASE_TH(RL), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .button_in(button_in),
    .button_out(button_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .scan_idx(scan_idx),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input logic [N-1:0] p, input logic [N-1:0] r,
                      input logic [N-1:0] o);
    ev_t e;
    e.press = p;
    e.rel   = r;
    e.out   = o;
    exp_q.push_back(e);
  endtask

  task automatic wait_idx(input logic [1:0] idx, input int max,
                          output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_idx != idx && n < max);
    if (scan_idx != idx) check("wait_idx_timeout", int'(scan_idx), int'(idx));
  endtask

  // Monitor: any pulse must match the next queued event
  always @(negedge clk) begin
    if (!reset && ((|press_pulse) === 1'b1 || (|release_pulse) === 1'b1)) begin
      check("pulse_onehot", $countones({press_pulse, release_pulse}), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'({press_pulse, release_pulse}), 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("press_pulse", int'(press_pulse), int'(e.press));
        check("release_pulse", int'(release_pulse), int'(e.rel));
        check("out_at_pulse", int'(button_out), int'(e.out));
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    enable = 1'b0;
    button_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out", int'(button_out), 0);
    check("rst_pulses", int'({press_pulse, release_pulse}), 0);
    check("rst_idx", int'(scan_idx), 0);
    check("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Fast press of button 0
    button_in = 4'b0001;
    enable = 1'b1;
    push(4'b0001, 4'b0000, 4'b0001);
    wait_idx(2'd1, 50, n);
    check("fast_slot_len", n, TH + 2);
    check("press0_out", int'(button_out), 1);

    // Button 1 alternating: hysteresis hold, full window
    n = 0;
    do begin
      button_in[1] = ((n % 2) == 0);
      @(negedge clk);
      n++;
    end while (scan_idx != 2'd2 && n < 40);
    check("alt_slot_len", n, W + 1);
    check("alt_out", int'(button_out), 1);

    // All low: wrap around and release button 0
    button_in = 4'b0000;
    push(4'b0000, 4'b0001, 4'b0000);
    wait_idx(2'd1, 100, n);
    check("release_out", int'(button_out), 0);
    check("release_busy", int'(busy), 1);

    // Abort button 2 after 5 samples, then restart fresh
    wait_idx(2'd2, 50, n);
    button_in = 4'b0100;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_idx", int'(scan_idx), 2);
    check("abort_out", int'(button_out), 0);
    repeat (2) @(negedge clk);
    check("abort_hold_busy", int'(busy), 0);
    check("abort_hold_idx", int'(scan_idx), 2);
    enable = 1'b1;
    push(4'b0100, 4'b0000, 4'b0100);
    wait_idx(2'd3, 50, n);
    check("restart_slot_len", n, TH + 2);
    check("restart_out", int'(button_out), 4);

    // Build button_out = 1010 then reset mid-SAMPLE
    button_in = 4'b1010;
    push(4'b1000, 4'b0000, 4'b1100);
    push(4'b0010, 4'b0000, 4'b1110);
    push(4'b0000, 4'b0100, 4'b1010);
    wait_idx(2'd0, 50, n);
    wait_idx(2'd3, 80, n);
    check("pre_reset_out", int'(button_out), 10);
    repeat (3) @(negedge clk);
    check("mid_sample_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_out", int'(button_out), 0);
    check("mid_rst_idx", int'(scan_idx), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pulses", int'({press_pulse, release_pulse}), 0);
    reset = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
